// File: rtl/adc_scan_scheduler_pkg.sv
// Shared types and helpers for the ADC scan scheduler: FSM state encoding,
// default channel geometry and the channel-slice offset helper.
package adc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_NUM   = 2;
    localparam int unsigned DEFAULT_WIDTH = 12;

    // Low bit of channel ch inside a flat NUM*width bus.
    function automatic int unsigned ch_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_if.sv
// Converter/result bundle between the scan scheduler (master) and the
// surrounding logic (slave): enable, converter handshake and snapshot bank.
interface adc_scan_scheduler_if
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM   = DEFAULT_NUM,
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic                 enable;
    logic [NUM-1:0]       adc_start;
    logic [NUM-1:0]       adc_ready;
    logic [NUM*WIDTH-1:0] adc_data;
    logic [NUM*WIDTH-1:0] result;
    logic [NUM-1:0]       valid;
    logic                 scan_done;
    logic                 busy;
    logic                 overrun;
    logic                 timeout;

    modport master (
        input  enable, adc_ready, adc_data,
        output adc_start, result, valid, scan_done, busy, overrun, timeout
    );

    modport slave (
        output enable, adc_ready, adc_data,
        input  adc_start, result, valid, scan_done, busy, overrun, timeout
    );

endinterface

// File: rtl/adc_scan_scheduler_timer.sv
// Period timer: counts PERIOD-1 down to 0 and ticks on the 0 cycle.
// While enable is low the count is parked at its reload value.
module adc_period_timer #(
    parameter int unsigned PERIOD = 1000
)(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(PERIOD);

    logic [CW-1:0] count;

    // Down-counter with reload on zero, held at reload while disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= CW'(PERIOD - 1);
        end else if (count == '0) begin
            count <= CW'(PERIOD - 1);
        end else begin
            count <= count - CW'(1);
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Periodic ADC scan controller. Each timer tick starts all converters,
// collects the first sample per channel into shadow registers and publishes
// them as one atomic snapshot. Dropped ticks pulse overrun.
// Optional feature: define ADC_SCHED_TIMEOUT_EN to close a scan after
// TIMEOUT WAIT cycles even if some converters never answered.
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned NUM     = DEFAULT_NUM,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned PERIOD  = 1000,
    parameter int unsigned TIMEOUT = 255
)(
    input logic                  clk,
    input logic                  reset,
    adc_scan_scheduler_if.master scan
);

    if (PERIOD < 4 || TIMEOUT < 1) begin : g_param_check
        $error("adc_scan_scheduler: PERIOD must be >= 4 and TIMEOUT >= 1");
    end

    state_t               state;
    state_t               next_state;
    logic                 tick;
    logic [NUM-1:0]       got;
    logic [NUM-1:0]       got_next;
    logic [NUM*WIDTH-1:0] shadow;
    logic [NUM*WIDTH-1:0] shadow_next;
    logic [NUM*WIDTH-1:0] result_q;
    logic [NUM-1:0]       valid_q;
    logic                 overrun_q;
    logic                 all_got;
    logic                 close_timeout;

    adc_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (scan.enable),
        .tick   (tick)
    );

    // Accept the first ready per channel during WAIT; repeats are ignored
    always_comb begin
        got_next    = got;
        shadow_next = shadow;
        if (state == WAIT) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                if (scan.adc_ready[i] && !got[i]) begin
                    got_next[i] = 1'b1;
                    shadow_next[ch_lo(i, WIDTH) +: WIDTH] = scan.adc_data[ch_lo(i, WIDTH) +: WIDTH];
                end
            end
        end
    end

    assign all_got = &got_next;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] wait_cnt;
    logic          timeout_q;

    // Count WAIT cycles of the current scan; START rearms the count
    always_ff @(posedge clk) begin
        if (reset || state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Closing on the TIMEOUT-th WAIT cycle only counts as a timeout if
    // that same cycle did not complete the channel set.
    assign close_timeout = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1)) && !all_got;

    // Timeout flag lines up with the DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= close_timeout;
        end
    end
`else
    assign close_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (tick) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (all_got || close_timeout) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Got mask, shadow, snapshot bank and overrun flag. The snapshot is
    // loaded on the WAIT->DONE edge from the merged shadow so that result
    // and valid are already updated in the DONE (scan_done) cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            got       <= '0;
            shadow    <= '0;
            result_q  <= '0;
            valid_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= tick && (state != IDLE);
            if (state == START) begin
                got <= '0;
            end else begin
                got    <= got_next;
                shadow <= shadow_next;
            end
            if (state == WAIT && next_state == DONE) begin
                for (int unsigned i = 0; i < NUM; i++) begin
                    if (got_next[i]) begin
                        result_q[ch_lo(i, WIDTH) +: WIDTH] <= shadow_next[ch_lo(i, WIDTH) +: WIDTH];
                    end
                end
                valid_q <= got_next;
            end
        end
    end

    // Output decode from registered state and flags only
    always_comb begin
        scan.adc_start = {NUM{state == START}};
        scan.busy      = (state != IDLE);
        scan.scan_done = (state == DONE);
        scan.result    = result_q;
        scan.valid     = valid_q;
        scan.overrun   = overrun_q;
`ifdef ADC_SCHED_TIMEOUT_EN
        scan.timeout   = timeout_q;
`else
        scan.timeout   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler (NUM=2, WIDTH=12, PERIOD=20,
// TIMEOUT=10). Timeout checks adapt to ADC_SCHED_TIMEOUT_EN.
module tb_adc_scan_scheduler;

    localparam int unsigned NUM     = 2;
    localparam int unsigned WIDTH   = 12;
    localparam int unsigned PERIOD  = 20;
    localparam int unsigned TIMEOUT = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_scan_scheduler_if #(.NUM(NUM), .WIDTH(WIDTH)) bus ();

    adc_scan_scheduler #(
        .NUM     (NUM),
        .WIDTH   (WIDTH),
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (bus)
    );

    // Converter model configuration (latency counted from the adc_start cycle)
    int          lat0 = 5, lat0b = -1, lat1 = 8;
    logic        on0 = 1'b1, on1 = 1'b1;
    logic [11:0] dat0 = 12'hABC, dat0b = 12'h000, dat1 = 12'h123;
    logic        rdy0 = 1'b0, rdy1 = 1'b0, stray0 = 1'b0;
    logic [11:0] d0 = '0, d1 = '0, sd = '0;

    assign bus.enable    = enable;
    assign bus.adc_ready = {rdy1, rdy0 | stray0};
    assign bus.adc_data  = {d1, (stray0 ? sd : d0)};

    // Converter model: latches its configuration on adc_start
    initial begin
        int age, l0, l0b, l1;
        logic o0, o1;
        logic [11:0] x0, x0b, x1;
        age = -1; l0 = 0; l0b = -1; l1 = 0; o0 = 0; o1 = 0; x0 = 0; x0b = 0; x1 = 0;
        forever begin
            @(posedge clk); #1;
            rdy0 = 1'b0;
            rdy1 = 1'b0;
            if (bus.adc_start != '0) begin
                age = 0;
                l0 = lat0; l0b = lat0b; l1 = lat1; o0 = on0; o1 = on1;
                x0 = dat0; x0b = dat0b; x1 = dat1;
            end else if (age >= 0 && age < 200) begin
                age++;
            end else begin
                age = -1;
            end
            if (age > 0) begin
                if (o0 && age == l0)  begin rdy0 = 1'b1; d0 = x0;  end
                if (o0 && age == l0b) begin rdy0 = 1'b1; d0 = x0b; end
                if (o1 && age == l1)  begin rdy1 = 1'b1; d1 = x1;  end
            end
        end
    end

    // Cycles (negedges) until adc_start is seen, bounded by budget
    task automatic wait_start(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.adc_start == '0 && n < budget);
        if (bus.adc_start == '0) n = -1;
    endtask

    // Cycles (negedges) until scan_done is seen, bounded by budget
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.scan_done !== 1'b1 && n < budget);
        if (bus.scan_done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++; if (bus.adc_start !== 2'b00) begin mismatched++; $display("FAIL reset_adc_start: got %b expected 00", bus.adc_start); end
        compared++; if (bus.result !== 24'h000000) begin mismatched++; $display("FAIL reset_result: got %h expected 000000", bus.result); end
        compared++; if (bus.valid !== 2'b00) begin mismatched++; $display("FAIL reset_valid: got %b expected 00", bus.valid); end
        compared++; if (bus.scan_done !== 1'b0) begin mismatched++; $display("FAIL reset_scan_done: got %b expected 0", bus.scan_done); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
        compared++; if (bus.timeout !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
        reset = 1'b0;
        wait_start(40, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL reset_first_tick: got %0d cycles expected 20", n); end
    endtask

    task automatic test_basic();
        int n;
        wait_start(30, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL basic_period: got %0d cycles expected 20", n); end
        wait_done(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL basic_latency: got %0d cycles expected 9", n); end
        compared++; if (bus.result !== 24'h123ABC) begin mismatched++; $display("FAIL basic_result: got %h expected 123abc", bus.result); end
        compared++; if (bus.valid !== 2'b11) begin mismatched++; $display("FAIL basic_valid: got %b expected 11", bus.valid); end
        compared++; if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_done: got %b expected 1", bus.busy); end
        @(negedge clk);
        compared++; if (bus.scan_done !== 1'b0) begin mismatched++; $display("FAIL basic_done_pulse: got %b expected 0", bus.scan_done); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle_busy: got %b expected 0", bus.busy); end
        wait_start(30, n);
        compared++; if (n != 10) begin mismatched++; $display("FAIL basic_next_start: got %0d cycles expected 10", n); end
    endtask

    task automatic test_overrun();
        int n, ov_cnt, ov_k, done_k, start_k;
        logic [23:0] res;
        lat0 = 25; lat1 = 25; dat0 = 12'h789; dat1 = 12'h456;
        wait_start(30, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL overrun_start: got %0d cycles expected 20", n); end
        ov_cnt = 0; ov_k = 0; done_k = 0; start_k = 0; res = '0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (bus.overrun === 1'b1) begin ov_cnt++; ov_k = k; end
            if (bus.scan_done === 1'b1 && done_k == 0) begin done_k = k; res = bus.result; end
            if (bus.adc_start != '0 && start_k == 0) start_k = k;
            if (k == 30) begin lat0 = 5; lat1 = 8; dat0 = 12'hABC; dat1 = 12'h123; end
        end
        compared++; if (ov_cnt != 1) begin mismatched++; $display("FAIL overrun_count: got %0d expected 1", ov_cnt); end
        compared++; if (ov_k != 20) begin mismatched++; $display("FAIL overrun_cycle: got %0d expected 20", ov_k); end
        compared++; if (done_k != 26) begin mismatched++; $display("FAIL overrun_done_cycle: got %0d expected 26", done_k); end
        compared++; if (res !== 24'h456789) begin mismatched++; $display("FAIL overrun_result: got %h expected 456789", res); end
        compared++; if (start_k != 40) begin mismatched++; $display("FAIL overrun_next_start: got %0d expected 40", start_k); end
    endtask

    task automatic test_dup();
        int n;
        lat0 = 3; lat0b = 6; dat0 = 12'h111; dat0b = 12'h222; dat1 = 12'h333;
        wait_start(30, n);
        compared++; if (n != 19) begin mismatched++; $display("FAIL dup_start: got %0d cycles expected 19", n); end
        wait_done(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL dup_latency: got %0d cycles expected 9", n); end
        compared++; if (bus.result !== 24'h333111) begin mismatched++; $display("FAIL dup_first_wins: got %h expected 333111", bus.result); end
        compared++; if (bus.valid !== 2'b11) begin mismatched++; $display("FAIL dup_valid: got %b expected 11", bus.valid); end
        @(negedge clk);
        stray0 = 1'b1; sd = 12'hFFF;
        @(negedge clk);
        stray0 = 1'b0;
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL stray_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.scan_done !== 1'b0) begin mismatched++; $display("FAIL stray_done: got %b expected 0", bus.scan_done); end
        compared++; if (bus.result !== 24'h333111) begin mismatched++; $display("FAIL stray_result: got %h expected 333111", bus.result); end
        lat0b = -1;
    endtask

    task automatic test_timeout();
        int n;
        lat0 = 3; dat0 = 12'h7FF;
`ifdef ADC_SCHED_TIMEOUT_EN
        on1 = 1'b0;
        wait_start(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL timeout_start: got %0d cycles expected 9", n); end
        wait_done(30, n);
        compared++; if (n != 11) begin mismatched++; $display("FAIL timeout_latency: got %0d cycles expected 11", n); end
        compared++; if (bus.timeout !== 1'b1) begin mismatched++; $display("FAIL timeout_pulse: got %b expected 1", bus.timeout); end
        compared++; if (bus.valid !== 2'b01) begin mismatched++; $display("FAIL timeout_valid: got %b expected 01", bus.valid); end
        compared++; if (bus.result !== 24'h3337FF) begin mismatched++; $display("FAIL timeout_result: got %h expected 3337ff", bus.result); end
`else
        wait_start(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL timeout_start: got %0d cycles expected 9", n); end
        wait_done(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL timeout_latency: got %0d cycles expected 9", n); end
        compared++; if (bus.timeout !== 1'b0) begin mismatched++; $display("FAIL timeout_tied: got %b expected 0", bus.timeout); end
        compared++; if (bus.valid !== 2'b11) begin mismatched++; $display("FAIL timeout_valid: got %b expected 11", bus.valid); end
        compared++; if (bus.result !== 24'h3337FF) begin mismatched++; $display("FAIL timeout_result: got %h expected 3337ff", bus.result); end
`endif
        @(negedge clk);
        compared++; if (bus.timeout !== 1'b0) begin mismatched++; $display("FAIL timeout_after: got %b expected 0", bus.timeout); end
        on1 = 1'b1; lat0 = 5; dat0 = 12'hABC; dat1 = 12'h123;
    endtask

    task automatic test_enable();
        int n, starts, busy_cnt;
        wait_done(40, n);
        compared++; if (bus.scan_done !== 1'b1) begin mismatched++; $display("FAIL enable_prev_done: got %b expected 1", bus.scan_done); end
        enable = 1'b0;
        starts = 0; busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.adc_start != '0) starts++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        compared++; if (starts != 0) begin mismatched++; $display("FAIL enable_low_starts: got %0d expected 0", starts); end
        compared++; if (busy_cnt != 0) begin mismatched++; $display("FAIL enable_low_busy: got %0d expected 0", busy_cnt); end
        enable = 1'b1;
        wait_start(40, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL enable_resume: got %0d cycles expected 20", n); end
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_done(20, n);
        compared++; if (n != 7) begin mismatched++; $display("FAIL enable_drop_done: got %0d cycles expected 7", n); end
        compared++; if (bus.result !== 24'h123ABC) begin mismatched++; $display("FAIL enable_drop_result: got %h expected 123abc", bus.result); end
        starts = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.adc_start != '0) starts++;
        end
        compared++; if (starts != 0) begin mismatched++; $display("FAIL enable_drop_starts: got %0d expected 0", starts); end
        enable = 1'b1;
    endtask

    task automatic test_reset_midscan();
        int n;
        wait_start(40, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL midreset_start: got %0d cycles expected 20", n); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.result !== 24'h000000) begin mismatched++; $display("FAIL midreset_result: got %h expected 000000", bus.result); end
        compared++; if (bus.valid !== 2'b00) begin mismatched++; $display("FAIL midreset_valid: got %b expected 00", bus.valid); end
        compared++; if (bus.adc_start !== 2'b00) begin mismatched++; $display("FAIL midreset_adc_start: got %b expected 00", bus.adc_start); end
        compared++; if (bus.scan_done !== 1'b0) begin mismatched++; $display("FAIL midreset_scan_done: got %b expected 0", bus.scan_done); end
        reset = 1'b0;
        wait_start(40, n);
        compared++; if (n != 20) begin mismatched++; $display("FAIL midreset_first_tick: got %0d cycles expected 20", n); end
        wait_done(30, n);
        compared++; if (n != 9) begin mismatched++; $display("FAIL midreset_latency: got %0d cycles expected 9", n); end
        compared++; if (bus.result !== 24'h123ABC) begin mismatched++; $display("FAIL midreset_result2: got %h expected 123abc", bus.result); end
        compared++; if (bus.valid !== 2'b11) begin mismatched++; $display("FAIL midreset_valid2: got %b expected 11", bus.valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_dup();
        test_timeout();
        test_enable();
        test_reset_midscan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Periodic scan controller for the bank of serial ADC converters instantiated at the top level. Every PERIOD clocks it fires one start pulse to all NUM converters, collects each channel's 12-bit result on its ready pulse, and publishes all results as one atomic snapshot. The top level therefore reads a coherent, registered result bank instead of raw per-converter outputs. It flags scans that could not start on time and, optionally, converters that never answered.

## Interface
Parameters:
- NUM, 2: number of ADC channels.
- WIDTH, 12: sample width per channel.
- PERIOD, 1000: clocks between scan ticks; must be ≥ 4.
- TIMEOUT, 255: maximum WAIT clocks per scan; used only with the timeout feature.

Ports:
- clk  in  1  system clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allows scan ticks.
- adc_start  out  NUM  one-cycle conversion start, one bit per converter.
- adc_ready  in  NUM  one-cycle pulse per converter; adc_data for that channel is valid in that cycle.
- adc_data  in  NUM*WIDTH  flat converter outputs; channel i is [i*WIDTH +: WIDTH].
- result  out  NUM*WIDTH  snapshot bank, same packing as adc_data.
- valid  out  NUM  per channel: 1 means result holds a value from the latest scan.
- scan_done  out  1  one-cycle pulse when the snapshot updates.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a tick is dropped.
- timeout  out  1  one-cycle pulse, coincident with scan_done, when the scan closed by timeout.

## Operation
- Period timer:
  - Counts PERIOD-1 down to 0, then reloads; a tick occurs on the 0 cycle.
  - With enable low, the timer holds at its reload value and produces no ticks.
- States:
  - IDLE: on tick, go to START.
  - START: adc_start = all ones for exactly one cycle; clear the got mask and the timeout counter; go to WAIT.
  - WAIT, each cycle, for every channel i with adc_ready[i]=1 and got[i]=0: store adc_data[i] in shadow[i] and set got[i].
  - WAIT → DONE when got is all ones after the update, or when the timeout counter reaches TIMEOUT (timeout feature only).
  - DONE: for channels with got[i]=1, result[i] ← shadow[i]; other channels keep their previous result. valid ← got. scan_done=1. Return to IDLE.
- Data rules:
  - A repeated ready for the same channel within one scan is ignored; the first value wins.
  - Ready pulses outside WAIT are ignored.
  - Data passes through unmodified; no arithmetic is applied to samples.
- Overrun:
  - A tick while state ≠ IDLE (including DONE) is dropped and overrun pulses for one cycle.
  - The scan in progress continues.
- enable falling mid-scan: the current scan completes normally; no further ticks.
- Reset, including mid-scan: state IDLE, timer reloaded. adc_start, result, valid, scan_done, busy, overrun and timeout all return to 0. The got mask and shadow registers clear.

## Timing
- Tick at cycle t:
  - adc_start high at t+1 (START).
  - WAIT from t+2.
- Ready pulses: earliest counted ready is at t+2.
- Last ready sampled in cycle w:
  - scan_done, result and valid updated at w+1.
  - IDLE at w+2.
- Minimum scan length: 3 cycles (START, one WAIT, DONE).
- After reset deasserts with enable high, the first tick occurs PERIOD cycles later.
- All outputs are registered; none depends combinationally on inputs.

## Configuration
- ADC_SCHED_TIMEOUT_EN defined:
  - WAIT counts cycles; on reaching TIMEOUT with got not all ones, go to DONE.
  - timeout pulses together with scan_done.
  - Missing channels get valid=0 and keep their old result.
- ADC_SCHED_TIMEOUT_EN undefined:
  - WAIT persists until all channels answer.
  - The timeout output is tied to 0, the TIMEOUT parameter is unused, and no counter is built.

## Structure
- Package adc_sched_pkg holds:
  - the state enumeration (IDLE, START, WAIT, DONE);
  - default WIDTH;
  - the channel-slice helper constants.
- Sub-module adc_period_timer (PERIOD parameter; ports clk, reset, enable, tick) generates ticks.
- The FSM, shadow registers and result registers live in the top of this block.
- The result bank is a flat vector of registers, not a memory array.

## Test plan
- NUM=2, PERIOD=20, enable=1; converter model answers ch0 after 5 cycles with 0xABC and ch1 after 8 cycles with 0x123 → result=={0x123,0xABC}, valid=2'b11, scan_done one cycle after the ch1 ready, scans repeat every 20 cycles.
- Converter models take 25 cycles with PERIOD=20 → overrun pulses at each tick landing in WAIT/DONE; scans complete every other period; result stays correct.
- Timeout enabled with TIMEOUT=10; ch1 never answers, ch0 returns 0x7FF → after 10 WAIT cycles timeout and scan_done pulse together; valid=2'b01; ch1 keeps its previous value.
- ch0 pulses ready twice in one scan (0x111 then 0x222) → result ch0==0x111.
- reset asserted during WAIT → next cycle all outputs are 0 and state is IDLE; the next tick arrives PERIOD cycles after reset release.
- enable held low for 100 cycles → no adc_start; enable dropped in WAIT → that scan still produces scan_done and no further ticks follow.
